// File: rtl/periph_pkg.sv
// Types and constants shared by the CPU-side sender and the local receiver.
// Holds the handshake state encodings and the transfer word width.
package periph_pkg;

    localparam int unsigned DATA_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_ACK        = 2'b01,
        ST_WAIT_SPACE = 2'b10
    } periph_state_e;

endpackage

// File: rtl/periph_fifo.sv
// Receive FIFO with first-word fall-through. Pointers wrap modulo DEPTH, and
// full/empty are derived from the occupancy count.
module periph_fifo
    import periph_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_wr, do_rd;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign level   = level_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Both guards use pre-edge occupancy, so a pop on a full FIFO never
    // admits a write on the same edge.
    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/periph_receiver.sv
// Receiver side of a 4-phase CPU handshake: synchronizes send, stores one
// word per request in a local FIFO and counts accepted words.
module periph_receiver
    import periph_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk1,
    input  logic                     rst1,
    input  logic                     send,
    input  logic [DATA_W-1:0]        dado,
    output logic                     ack,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               rx_count
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    periph_state_e          state_q, state_d;
    logic [7:0]             rx_count_q, rx_count_d;
    logic                   send_s;
    logic                   wr_en;

    assign send_s   = sync_q[SYNC_STAGES-1];
    assign ack      = (state_q == ST_ACK);
    assign rx_count = rx_count_q;

    // A word is written only on the leaving edge of IDLE/WAIT_SPACE, so a
    // held send yields exactly one write until it drops back to IDLE.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], send};
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (send_s) begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT_SPACE;
                    end
                end
            end
            ST_WAIT_SPACE: begin
                if (!send_s) begin
                    state_d = ST_IDLE;
                end else if (!full) begin
                    wr_en   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!send_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rx_count_d = rx_count_q;
        if (wr_en && (rx_count_q != 8'hFF)) begin
            rx_count_d = rx_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst1) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            rx_count_q <= '0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            rx_count_q <= rx_count_d;
        end
    end

    periph_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk1),
        .rst     (rst1),
        .wr_en   (wr_en),
        .wr_data (dado),
        .rd_en   (rd_en),
        .rd_data (dout),
        .empty   (empty),
        .full    (full),
        .level   (level)
    );

endmodule

// File: tb/tb_periph_receiver.sv
// Scoreboard bench for periph_receiver: accepted words are queued when driven
// and compared against dout as they are popped.
module tb_periph_receiver;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;
    localparam int          LAT   = SYNC + 1;

    logic       clk1 = 1'b0;
    logic       rst1;
    logic       send;
    logic [1:0] dado;
    logic       ack;
    logic       rd_en;
    logic [1:0] dout;
    logic       empty;
    logic       full;
    logic [2:0] level;
    logic [7:0] rx_count;

    int         checks = 0;
    int         errors = 0;
    int         exp_rx = 0;
    logic [1:0] exp_q[$];

    periph_receiver #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk1     (clk1),
        .rst1     (rst1),
        .send     (send),
        .dado     (dado),
        .ack      (ack),
        .rd_en    (rd_en),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .rx_count (rx_count)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic wait_ack(input logic val, output int n);
        n = 0;
        while (ack !== val && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ack_timeout", 32'(ack), 32'(val));
    endtask

    task automatic bump_rx();
        if (exp_rx < 255) exp_rx++;
    endtask

    task automatic handshake(input logic [1:0] d);
        int n;
        dado = d;
        send = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, n);
        chk("ack_rise_lat", 32'(n), 32'(LAT));
        bump_rx();
        chk("rx_count", 32'(rx_count), 32'(exp_rx));
        send = 1'b0;
        wait_ack(1'b0, n);
        chk("ack_fall_lat", 32'(n), 32'(LAT));
    endtask

    task automatic pop_check();
        logic [1:0] e;
        chk("not_empty", 32'(empty), 32'd0);
        e = exp_q.pop_front();
        chk("dout", 32'(dout), 32'(e));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        int         n;
        logic [1:0] e;
        rst1  = 1'b1;
        send  = 1'b0;
        dado  = 2'b00;
        rd_en = 1'b0;
        repeat (3) tick();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rx", 32'(rx_count), 32'd0);
        rst1 = 1'b0;

        // Single transfer with explicit cycle-by-cycle ack timing
        dado = 2'b10;
        send = 1'b1;
        exp_q.push_back(2'b10);
        tick(); tick();
        chk("single_ack_early", 32'(ack), 32'd0);
        tick();
        chk("single_ack_c3", 32'(ack), 32'd1);
        bump_rx();
        chk("single_level", 32'(level), 32'd1);
        chk("single_dout", 32'(dout), 32'd2);
        chk("single_rx", 32'(rx_count), 32'(exp_rx));
        send = 1'b0;
        tick(); tick();
        chk("single_ack_hold", 32'(ack), 32'd1);
        tick();
        chk("single_ack_drop", 32'(ack), 32'd0);
        pop_check();
        chk("single_empty", 32'(empty), 32'd1);

        // Fill to full, then a pending fifth request waits for space
        for (int i = 0; i < 4; i++) handshake(2'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd4);
        dado = 2'b10;
        send = 1'b1;
        exp_q.push_back(2'b10);
        repeat (6) tick();
        chk("wait_ack_low", 32'(ack), 32'd0);
        chk("wait_level", 32'(level), 32'd4);
        pop_check();
        wait_ack(1'b1, n);
        chk("accept_after_pop", 32'(n), 32'd1);
        bump_rx();
        chk("after_pop_dout", 32'(dout), 32'd1);
        chk("after_pop_level", 32'(level), 32'd4);
        chk("after_pop_rx", 32'(rx_count), 32'(exp_rx));
        send = 1'b0;
        wait_ack(1'b0, n);

        // Full plus pop on the same edge as a pending write
        dado = 2'b11;
        send = 1'b1;
        exp_q.push_back(2'b11);
        repeat (4) tick();
        chk("pend_ack_low", 32'(ack), 32'd0);
        e = exp_q.pop_front();
        chk("pend_dout", 32'(dout), 32'(e));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pend_pop_level", 32'(level), 32'd3);
        chk("pend_pop_ack", 32'(ack), 32'd0);
        tick();
        bump_rx();
        chk("pend_wr_level", 32'(level), 32'd4);
        chk("pend_wr_ack", 32'(ack), 32'd1);
        send = 1'b0;
        wait_ack(1'b0, n);
        while (exp_q.size() > 0) pop_check();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_rx", 32'(rx_count), 32'(exp_rx));

        // Held send writes once
        dado = 2'b01;
        send = 1'b1;
        exp_q.push_back(2'b01);
        repeat (20) tick();
        bump_rx();
        chk("held_rx", 32'(rx_count), 32'(exp_rx));
        chk("held_level", 32'(level), 32'd1);
        send = 1'b0;
        wait_ack(1'b0, n);
        pop_check();

        // Reset during ACK with send still high
        dado = 2'b11;
        send = 1'b1;
        wait_ack(1'b1, n);
        rst1 = 1'b1;
        tick();
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_rx", 32'(rx_count), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        rst1 = 1'b0;
        exp_q.delete();
        exp_rx = 0;
        exp_q.push_back(2'b11);
        wait_ack(1'b1, n);
        chk("reaccept_lat", 32'(n), 32'(LAT));
        bump_rx();
        chk("reaccept_rx", 32'(rx_count), 32'(exp_rx));
        send = 1'b0;
        wait_ack(1'b0, n);
        pop_check();

        // Saturation with a pop after every handshake
        for (int i = 0; i < 300; i++) begin
            handshake(2'($urandom_range(0, 3)));
            pop_check();
        end
        chk("sat_rx", 32'(rx_count), 32'd255);
        chk("sat_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
